// File: rtl/adex_pkg.sv
// Shared constants, intermediate type and clamp helper for the AdEx neuron.
package adex_pkg;

    localparam int unsigned DefWidth     = 8;
    localparam int unsigned DefVT        = 128;
    localparam int unsigned DefVPeak     = 240;
    localparam int unsigned DefVReset    = 32;
    localparam int unsigned DefBInc      = 16;
    localparam int unsigned DefLeakShift = 3;
    localparam int unsigned DefExpShift  = 4;
    localparam int unsigned DefWShift    = 4;
    localparam int unsigned DefRefrac    = 4;

    // Signed intermediate at the default width: three guard bits cover sign and carries.
    typedef logic signed [DefWidth+2:0] acc_t;

    function automatic int clamp_val(int x, int hi);
        if (x < 0) begin
            return 0;
        end
        if (x > hi) begin
            return hi;
        end
        return x;
    endfunction

endpackage

// File: rtl/adex_exp_term.sv
// Combinational exponential term: 1 << min((v - V_T) >> EXP_SHIFT, WIDTH-1) above V_T, else 0.
module adex_exp_term #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned V_T       = 128,
    parameter int unsigned EXP_SHIFT = 4
) (
    input  logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] exp_val
);

    int unsigned v_ext;
    int unsigned k;

    always_comb begin
        v_ext   = 32'(v);
        k       = 0;
        exp_val = '0;
        if (v_ext > V_T) begin
            k = (v_ext - V_T) >> EXP_SHIFT;
            if (k > WIDTH - 1) begin
                k = WIDTH - 1;
            end
            exp_val = WIDTH'(1) << k;
        end
    end

endmodule

// File: rtl/adex_neuron.sv
// Adaptive exponential integrate-and-fire neuron with spike-triggered adaptation,
// absolute refractory period and update-enable strobe.
module adex_neuron
    import adex_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned V_T        = DefVT,
    parameter int unsigned V_PEAK     = DefVPeak,
    parameter int unsigned V_RESET    = DefVReset,
    parameter int unsigned B_INC      = DefBInc,
    parameter int unsigned LEAK_SHIFT = DefLeakShift,
    parameter int unsigned EXP_SHIFT  = DefExpShift,
    parameter int unsigned W_SHIFT    = DefWShift,
    parameter int unsigned REFRAC     = DefRefrac
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] current,
    output logic             spike,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] adapt,
    output logic             refractory
);

    localparam int unsigned AccW   = WIDTH + 3;
    localparam int unsigned CntW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int          MaxVal = int'((64'd1 << WIDTH) - 64'd1);

    logic [WIDTH-1:0]       v_q, v_d, w_q, w_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   spike_q, spike_d, refr_q, refr_d;
    logic [WIDTH-1:0]       exp_val, w_decay;
    logic signed [AccW-1:0] v_acc, w_acc;

    adex_exp_term #(
        .WIDTH    (WIDTH),
        .V_T      (V_T),
        .EXP_SHIFT(EXP_SHIFT)
    ) u_exp_term (
        .v      (v_q),
        .exp_val(exp_val)
    );

    always_comb begin
        v_d     = v_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        w_decay = w_q - (w_q >> W_SHIFT);
        v_acc   = AccW'(v_q) - AccW'(v_q >> LEAK_SHIFT) + AccW'(current)
                + AccW'(exp_val) - AccW'(w_q);
        w_acc   = AccW'(w_decay) + AccW'(B_INC);
        if (en) begin
            if (cnt_q != '0) begin
                v_d   = WIDTH'(V_RESET);
                w_d   = w_decay;
                cnt_d = cnt_q - CntW'(1);
            end else if (v_acc >= $signed(AccW'(V_PEAK))) begin
                // Spike is judged on the unclamped sum.
                v_d     = WIDTH'(V_RESET);
                w_d     = WIDTH'(clamp_val(int'(w_acc), MaxVal));
                cnt_d   = CntW'(REFRAC);
                spike_d = 1'b1;
            end else begin
                v_d = WIDTH'(clamp_val(int'(v_acc), MaxVal));
                w_d = w_decay;
            end
        end
        refr_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q     <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
            refr_q  <= 1'b0;
        end else begin
            v_q     <= v_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
            refr_q  <= refr_d;
        end
    end

    assign state      = v_q;
    assign adapt      = w_q;
    assign spike      = spike_q;
    assign refractory = refr_q;

endmodule
